// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage.
package fetch_unit_pkg;

    typedef logic [31:0] cpu_word;
    typedef logic [31:0] cpu_addr;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_RUN,
        FETCH_HALT_DRAIN,
        FETCH_HALTED
    } fetch_state;

    // One instruction queue entry: byte PC plus the fetched word.
    typedef struct packed {
        cpu_addr pc;
        cpu_word word;
    } fetch_entry;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with synchronous clear. DEPTH must be a power of 2.
// A push at full is accepted when a pop happens in the same cycle.
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    // Pointer/count next state; clear wins over any push or pop.
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == (AW+1)'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push) wr_d = wr_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count says valid.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_q] <= wdata;
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, queues returned
// words for the decoder, and handles redirect/halt by flushing the queue and
// dropping in-flight responses. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        memReqValid,
    input  logic        memReqReady,
    output logic [31:0] memReqAddr,
    input  logic        memRspValid,
    input  logic [31:0] memRspData,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instWord,
    output logic [31:0] instPc,
    input  logic        redirectEn,
    input  logic [31:0] redirectPc,
    input  logic        haltReq,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perfFetched,
    output logic [31:0] perfDropped,
    output logic [31:0] perfStall
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state    state_q, state_d;
    cpu_addr       pc_q, pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] qCount, outCnt;
    logic [CW:0]   occ;
    logic          qEmpty, qFull, sEmpty, sFull;
    logic          run, accept, rspDrop, push, pop, flush;
    fetch_entry    qIn, qOut;
    cpu_addr       rspPc;
    logic          unused_bits;

    assign unused_bits = ^{qFull, sEmpty, redirectPc[1:0]};

    // Handshakes, credit, PC/drop/state next state.
    always_comb begin
        run     = (state_q == FETCH_RUN);
        // Slots already claimed: queued words plus live (non-dropped) requests.
        occ     = {1'b0, qCount} + {1'b0, outCnt} - {1'b0, drop_q};
        // The shadow FIFO bounds outstanding requests even while drops are pending.
        memReqValid = rst_n && run && (occ < (CW+1)'(DEPTH)) && !sFull;
        memReqAddr  = pc_q;
        accept  = memReqValid && memReqReady;
        rspDrop = memRspValid && (drop_q != '0);
        push    = memRspValid && (drop_q == '0);
        pop     = instValid && instReady;
        flush   = run && (haltReq || redirectEn);

        pc_d = pc_q;
        if (accept) pc_d = pc_q + cpu_addr'(INSTR_BYTES);
        if (run && !haltReq && redirectEn) pc_d = {redirectPc[31:2], 2'b00};

        drop_d = drop_q - CW'(rspDrop);
        if (flush) drop_d = outCnt + CW'(accept) - CW'(memRspValid);

        state_d = state_q;
        case (state_q)
            FETCH_RUN:        if (haltReq) state_d = FETCH_HALT_DRAIN;
            FETCH_HALT_DRAIN: if (outCnt == CW'(memRspValid)) state_d = FETCH_HALTED;
            default:          ;
        endcase
    end

    // State, PC and drop counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

    // PC shadow: addresses of outstanding requests, popped by every response.
    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_shadow (
        .clk(clk), .rst_n(rst_n), .clr(1'b0),
        .push(accept), .pop(memRspValid),
        .wdata(pc_q), .rdata(rspPc),
        .count(outCnt), .full(sFull), .empty(sEmpty)
    );

    assign qIn = '{pc: rspPc, word: memRspData};

    // Instruction queue feeding the decoder.
    fetch_queue #(.WIDTH($bits(fetch_entry)), .DEPTH(DEPTH)) u_iq (
        .clk(clk), .rst_n(rst_n), .clr(flush),
        .push(push), .pop(pop),
        .wdata(qIn), .rdata(qOut),
        .count(qCount), .full(qFull), .empty(qEmpty)
    );

    assign instValid = !qEmpty;
    assign instWord  = qOut.word;
    assign instPc    = qOut.pc;
    assign halted    = (state_q == FETCH_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, dropped_q, stall_q;

    // Free-running event counters; a word pushed during a flush is also discarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetched_q <= '0;
            dropped_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(accept);
            dropped_q <= dropped_q + 32'(rspDrop || (push && flush));
            stall_q   <= stall_q + 32'(instValid && !instReady);
        end
    end

    assign perfFetched = fetched_q;
    assign perfDropped = dropped_q;
    assign perfStall   = stall_q;
`endif

endmodule
